// File: rtl/pc_gen.sv
// Fetch-stage program counter with a priority next-PC selector and a
// return-address stack fed by same-cycle predecode of the instruction at pc.
module pc_gen #(
  parameter int              XLEN         = 32,
  parameter logic [XLEN-1:0] RESET_VECTOR = 32'hBFC00000,
  parameter int              RAS_DEPTH    = 4
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           en,
  input  logic                           ex_redirect,
  input  logic [XLEN-1:0]                ex_target,
  input  logic                           ex_is_jalr,
  input  logic                           pd_call,
  input  logic                           pd_ret,
  input  logic                           pd_jal,
  input  logic [XLEN-1:0]                pd_target,
  output logic [XLEN-1:0]                pc,
  output logic [XLEN-1:0]                pc_plus4,
  output logic                           pred_taken,
  output logic                           misaligned,
  output logic [$clog2(RAS_DEPTH):0]     ras_count
);

  localparam int PW = $clog2(RAS_DEPTH);
  localparam int CW = PW + 1;

  logic [XLEN-1:0] r_pc;
  logic [XLEN-1:0] r_ras [RAS_DEPTH];
  logic [PW-1:0]   r_sp;
  logic [CW-1:0]   r_cnt;

  logic            w_upd;
  logic            w_pop;
  logic [XLEN-1:0] w_pc_plus4;
  logic [XLEN-1:0] w_top;
  logic [XLEN-1:0] w_ex_target;
  logic [XLEN-1:0] w_next;
  logic [PW-1:0]   w_wr_idx;

  assign w_upd       = en & ~ex_redirect & ~rst;
  assign w_pop       = pd_ret & (r_cnt != '0);
  assign w_pc_plus4  = r_pc + XLEN'(4);
  assign w_top       = r_ras[r_sp];
  assign w_ex_target = ex_target & ~{{(XLEN-1){1'b0}}, ex_is_jalr};
  // A coroutine swap overwrites the current top instead of pushing above it.
  assign w_wr_idx    = w_pop ? r_sp : r_sp + PW'(1);

  always_comb begin
    w_next = w_pc_plus4;
    if (rst)              w_next = RESET_VECTOR;
    else if (ex_redirect) w_next = w_ex_target;
    else if (!en)         w_next = r_pc;
    else if (w_pop)       w_next = w_top;
    else if (pd_jal)      w_next = pd_target;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_pc  <= RESET_VECTOR;
      r_sp  <= '0;
      r_cnt <= '0;
    end else begin
      r_pc <= w_next;
      if (w_upd) begin
        if (pd_call && !w_pop) begin
          r_sp <= r_sp + PW'(1);
          if (r_cnt != CW'(RAS_DEPTH)) r_cnt <= r_cnt + CW'(1);
        end else if (w_pop && !pd_call) begin
          r_sp  <= r_sp - PW'(1);
          r_cnt <= r_cnt - CW'(1);
        end
      end
    end
  end

  // Entry storage is never reset; validity is tracked by r_cnt alone.
  always_ff @(posedge clk) begin
    if (w_upd && pd_call) r_ras[w_wr_idx] <= w_pc_plus4;
  end

  assign pc         = r_pc;
  assign pc_plus4   = w_pc_plus4;
  assign pred_taken = w_upd & (w_pop | pd_jal);
  assign misaligned = |r_pc[1:0];
  assign ras_count  = r_cnt;

endmodule

// File: doc/pc_gen.md
# pc_gen

Parametrised program-counter generator for the fetch stage. It replaces the fixed single-path PC register with a priority next-PC selector covering reset, execute redirect, stall, return prediction, jump prediction and sequential fetch. It also contains a configurable-depth return-address stack (RAS) driven by same-cycle predecode of the instruction at `pc`. It sits between the execute-stage branch/JALR resolution and the asynchronous-read instruction memory.

## Interface
- `XLEN`, default 32, address width in bits.
- `RESET_VECTOR`, default 32'hBFC00000, value loaded into `pc` on reset.
- `RAS_DEPTH`, default 4, number of RAS entries (power of two, ≥2).
- `clk`  in  1  clock; all state updates on rising edge.
- `rst`  in  1  reset, synchronous, active-high.
- `en`  in  1  fetch enable; low = stall, which holds `pc` and the RAS.
- `ex_redirect`  in  1  execute stage resolved a taken branch, JAL or JALR, or a mispredict.
- `ex_target`  in  XLEN  redirect address.
- `ex_is_jalr`  in  1  redirect originates from JALR; bit 0 of `ex_target` is cleared.
- `pd_call`  in  1  instruction at `pc` is JAL/JALR with rd ∈ {x1,x5}.
- `pd_ret`  in  1  instruction at `pc` is JALR with rs1 ∈ {x1,x5}, rd = x0.
- `pd_jal`  in  1  instruction at `pc` is JAL (direct target known).
- `pd_target`  in  XLEN  pc + J-immediate for JAL.
- `pc`  out  XLEN  current fetch address (register).
- `pc_plus4`  out  XLEN  `pc` + 4, combinational.
- `pred_taken`  out  1  this cycle's next-PC is non-sequential due to prediction, combinational.
- `misaligned`  out  1  `pc[1:0]` != 0, combinational from the register.
- `ras_count`  out  clog2(RAS_DEPTH)+1  valid RAS entries, saturating at RAS_DEPTH.

## Operation
- Next-PC priority, highest first:
  - `rst`: loads RESET_VECTOR.
  - `ex_redirect`: loads `ex_target`, with bit 0 cleared when `ex_is_jalr`.
  - `!en`: holds `pc`.
  - `pd_ret` with `ras_count` > 0: loads RAS top.
  - `pd_jal`: loads `pd_target`.
  - Otherwise: loads `pc_plus4`.
- `ex_redirect` overrides a stall. Flush always wins.
- `pred_taken` = `en` & !`ex_redirect` & !`rst` & ((`pd_ret` & `ras_count`>0) | `pd_jal`).
- `pd_ret` with an empty RAS falls back to `pc_plus4` and does not decrement the count. Execute later corrects the PC via redirect.
- RAS updates only in a cycle with `en`=1, `ex_redirect`=0 and `rst`=0.
- Push (`pd_call` only): writes `pc_plus4` at top+1, then increments the pointer. `ras_count` saturates at RAS_DEPTH.
- Overflow: the pointer wraps modulo RAS_DEPTH and the oldest entry is overwritten silently.
- Pop (`pd_ret` only, count > 0): the predicted target is the top entry. The pointer decrements modulo RAS_DEPTH and the count decrements.
- Pop and push in the same cycle (`pd_ret`&`pd_call`, coroutine swap):
  - The predicted target is the old top.
  - The top entry is replaced with `pc_plus4`.
  - Pointer and count are unchanged.
  - If the count is 0, this acts as a plain push and the next PC is `pc_plus4`.
- `pd_call` with `pd_jal` (JAL x1): push and jump to `pd_target`.
- `pd_call` alone (JALR call): push only; the next PC is `pc_plus4` until execute redirects.
- The RAS is not checkpointed. Redirects do not repair it. Mispredicted pushes and pops persist (accepted accuracy loss).
- Misaligned targets are still loaded into `pc`. `misaligned` flags them for the trap logic; this block takes no further action.
- All adds are modulo 2^XLEN. `pc_plus4` from 32'hFFFFFFFC is 32'h00000000.

## Timing
- Reset values: `pc` = RESET_VECTOR, `ras_count` = 0, RAS pointer = 0, `pred_taken` = 0 while `rst`=1. RAS entry contents are don't-care.
- Reset asserted mid-operation overrides every other input in that cycle. The RAS is emptied.
- Next-PC latency is 1 cycle: inputs sampled at edge N determine `pc` after edge N.
- `pd_*` are combinational from `pc` via async instruction memory. They must settle within the same cycle; there is no handshake.
- `ex_redirect` is a single-cycle pulse. If held high, `pc` reloads `ex_target` every cycle.
- During a stall (`en`=0), `pd_*` are ignored, `pred_taken` = 0, and the RAS is frozen.

## Test plan
- Reset, then 3 cycles with `en`=1 and no predecode: `pc` = BFC00000 → BFC00004 → BFC00008 → BFC0000C. `ras_count` = 0.
- At `pc`=BFC00010, `pd_call`&`pd_jal`, `pd_target`=BFC00100. Next cycle at BFC00100 assert `pd_ret`:
  - After the first edge: `pc`=BFC00100, `ras_count`=1.
  - After the second edge: `pc`=BFC00014, `ras_count`=0, and `pred_taken` was 1 in both cycles.
- With RAS_DEPTH=4, perform 5 pushes from PCs A0..A4, then 5 pops:
  - Pops return A4+4, A3+4, A2+4, A1+4.
  - `ras_count` sticks at 4 and then falls to 0.
  - The 5th pop falls back to `pc_plus4` with `pred_taken`=0.
- `en`=0 together with `ex_redirect`=1, `ex_target`=00001235, `ex_is_jalr`=1: `pc`=00001234 next cycle. `misaligned`=0. RAS unchanged.
- Stall for 3 cycles with `pd_call`=1: `pc` is held and `ras_count` is unchanged. With `ex_target`=00001002: `pc`=00001002 and `misaligned`=1.
- `pd_ret`&`pd_call` with top=00002000 at `pc`=00003000: next `pc`=00002000, top=00003004, count unchanged. Asserting `rst` on the following cycle gives `pc`=BFC00000 and `ras_count`=0.
